regfile_sb: RTL and testbench

Parameterised multi-port register file with a per-register scoreboard, the next generation of the datapath's 16-bit, 8-entry register file. It provides two combinational read ports, one synchronous write port with write-to-read bypass, and pending-write tracking. The issue stage uses the pending state to stall on read-after-write hazards; the writeback stage writes results and clears the pending state. It sits between decode/issue (read and reserve) and writeback (write).

---
 rtl/regfile_sb.sv | 106 ++++++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port with same-cycle
// bypass, and a per-register pending scoreboard for read-after-write hazard stalls.
module regfile_sb #(
  parameter int DW      = 16,
  parameter int NREG    = 8,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [AW-1:0] RD_ADDR_A,
  input  logic [AW-1:0] RD_ADDR_B,
  output logic [DW-1:0] RD_DATA_A,
  output logic [DW-1:0] RD_DATA_B,
  output logic          BUSY_A,
  output logic          BUSY_B,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [DW-1:0] WR_DATA,
  input  logic          RSV_EN,
  input  logic [AW-1:0] RSV_ADDR,
  output logic [AW:0]   PEND_CNT,
  output logic          ERR
);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;
  logic [DW-1:0]   rd_a;
  logic [DW-1:0]   rd_b;
  logic            wr_ok;
  logic            rsv_ok;
  logic            byp_a;
  logic            byp_b;
  logic            err_set;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(NREG);
  endfunction

  // Address that really maps to storage: in range and not the hardwired zero register.
  function automatic logic usable(input logic [AW-1:0] a);
    return in_range(a) && !(ZERO_R0 != 0 && a == '0);
  endfunction

  function automatic logic bit_at(input logic [NREG-1:0] v, input logic [AW-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (a == AW'(i)) r = v[i];
    return r;
  endfunction

  assign wr_ok  = WR_EN && usable(WR_ADDR);
  assign rsv_ok = RSV_EN && usable(RSV_ADDR);
  assign byp_a  = wr_ok && (WR_ADDR == RD_ADDR_A);
  assign byp_b  = wr_ok && (WR_ADDR == RD_ADDR_B);

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (RD_ADDR_A == AW'(i)) rd_a = regs[i];
      if (RD_ADDR_B == AW'(i)) rd_b = regs[i];
    end
  end

  assign RD_DATA_A = !RSTn ? '0 : byp_a ? WR_DATA : usable(RD_ADDR_A) ? rd_a : '0;
  assign RD_DATA_B = !RSTn ? '0 : byp_b ? WR_DATA : usable(RD_ADDR_B) ? rd_b : '0;
  assign BUSY_A    = RSTn && usable(RD_ADDR_A) && bit_at(pending, RD_ADDR_A) && !byp_a;
  assign BUSY_B    = RSTn && usable(RD_ADDR_B) && bit_at(pending, RD_ADDR_B) && !byp_b;

  // Reserve is applied after the write so a same-address reserve keeps the bit set.
  always_comb begin
    pend_nxt = pending;
    cnt_nxt  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (wr_ok && WR_ADDR == AW'(i)) pend_nxt[i] = 1'b0;
      if (rsv_ok && RSV_ADDR == AW'(i)) pend_nxt[i] = 1'b1;
    end
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
  end

  assign err_set = (WR_EN && !in_range(WR_ADDR))
                || (RSV_EN && !in_range(RSV_ADDR))
                || (wr_ok && !bit_at(pending, WR_ADDR))
                || (rsv_ok && bit_at(pending, RSV_ADDR) && !(wr_ok && WR_ADDR == RSV_ADDR));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pending  <= '0;
      PEND_CNT <= '0;
      ERR      <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (wr_ok && WR_ADDR == AW'(i)) regs[i] <= WR_DATA;
      pending  <= pend_nxt;
      PEND_CNT <= cnt_nxt;
      ERR      <= ERR | err_set;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default instance (8 regs) and a ZERO_R0
// instance (6 regs) share stimulus and are checked against an array-based model.
module tb_regfile_sb;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  aa, ab, wa, ra;
  logic        we, re;
  logic [15:0] wd;
  logic [15:0] da0, db0, da1, db1;
  logic        ba0, bb0, ba1, bb1, err0, err1;
  logic [4:0]  cnt0, cnt1;

  always #5 CLK = ~CLK;

  regfile_sb #(.DW(16), .NREG(8), .AW(4), .ZERO_R0(0)) dut0 (
    .CLK(CLK), .RSTn(RSTn), .RD_ADDR_A(aa), .RD_ADDR_B(ab), .RD_DATA_A(da0), .RD_DATA_B(db0),
    .BUSY_A(ba0), .BUSY_B(bb0), .WR_EN(we), .WR_ADDR(wa), .WR_DATA(wd), .RSV_EN(re),
    .RSV_ADDR(ra), .PEND_CNT(cnt0), .ERR(err0));

  regfile_sb #(.DW(16), .NREG(6), .AW(4), .ZERO_R0(1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .RD_ADDR_A(aa), .RD_ADDR_B(ab), .RD_DATA_A(da1), .RD_DATA_B(db1),
    .BUSY_A(ba1), .BUSY_B(bb1), .WR_EN(we), .WR_ADDR(wa), .WR_DATA(wd), .RSV_EN(re),
    .RSV_ADDR(ra), .PEND_CNT(cnt1), .ERR(err1));

  typedef struct {
    int          id;
    logic [15:0] da, db;
    logic        ba, bb;
    logic [4:0]  cnt;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_reg [2][16];
  bit          m_pend [2][16];
  bit          m_err [2];
  int          m_nreg [2] = '{8, 6};
  bit          m_z [2] = '{1'b0, 1'b1};

  function automatic bit ok_addr(int k, int a);
    return (a < m_nreg[k]) && !(m_z[k] && a == 0);
  endfunction

  function automatic logic [15:0] rd(int k, int a);
    if (!RSTn || !ok_addr(k, a)) return 16'h0;
    if (we && int'(wa) == a) return wd;
    return m_reg[k][a];
  endfunction

  function automatic bit busy(int k, int a);
    return RSTn && ok_addr(k, a) && m_pend[k][a] && !(we && int'(wa) == a);
  endfunction

  function automatic exp_t predict(int k);
    exp_t e;
    int   n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_pend[k][i]);
    e.id  = k;
    e.da  = rd(k, int'(aa));
    e.db  = rd(k, int'(ab));
    e.ba  = busy(k, int'(aa));
    e.bb  = busy(k, int'(ab));
    e.cnt = 5'(n);
    e.err = m_err[k];
    return e;
  endfunction

  task automatic model_edge(int k);
    bit wv, rv;
    wv = we && ok_addr(k, int'(wa));
    rv = re && ok_addr(k, int'(ra));
    if (we && int'(wa) >= m_nreg[k]) m_err[k] = 1'b1;
    if (re && int'(ra) >= m_nreg[k]) m_err[k] = 1'b1;
    if (wv && !m_pend[k][wa]) m_err[k] = 1'b1;
    if (rv && m_pend[k][ra] && !(wv && wa == ra)) m_err[k] = 1'b1;
    if (wv) begin
      m_reg[k][wa]  = wd;
      m_pend[k][wa] = 1'b0;
    end
    if (rv) m_pend[k][ra] = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[k][i]  = 16'h0;
        m_pend[k][i] = 1'b0;
      end
      m_err[k] = 1'b0;
    end
  endtask

  task automatic step(input bit we_i, input int wa_i, input logic [15:0] wd_i,
                      input bit re_i, input int ra_i, input int aa_i, input int ab_i);
    we = we_i; wa = 4'(wa_i); wd = wd_i;
    re = re_i; ra = 4'(ra_i); aa = 4'(aa_i); ab = 4'(ab_i);
    sb.push_back(predict(0));
    sb.push_back(predict(1));
    @(posedge CLK);
    if (RSTn) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
  endtask

  // Asserted between edges; outputs must clear at once even with a write presented.
  task automatic reset_mid();
    RSTn = 1'b0;
    model_reset();
    step(1'b1, 3, 16'hdead, 1'b1, 3, 3, 3);
    RSTn = 1'b1;
  endtask

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s got=%h want=%h at %0t", k, nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.id == 0) begin
          chk("rd_data_a", 0, da0, e.da);
          chk("rd_data_b", 0, db0, e.db);
          chk("busy_a", 0, 16'(ba0), 16'(e.ba));
          chk("busy_b", 0, 16'(bb0), 16'(e.bb));
          chk("pend_cnt", 0, 16'(cnt0), 16'(e.cnt));
          chk("err", 0, 16'(err0), 16'(e.err));
        end else begin
          chk("rd_data_a", 1, da1, e.da);
          chk("rd_data_b", 1, db1, e.db);
          chk("busy_a", 1, 16'(ba1), 16'(e.ba));
          chk("busy_b", 1, 16'(bb1), 16'(e.bb));
          chk("pend_cnt", 1, 16'(cnt1), 16'(e.cnt));
          chk("err", 1, 16'(err1), 16'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    we = 1'b0; wa = '0; wd = '0; re = 1'b0; ra = '0; aa = '0; ab = '0;
    model_reset();
    @(posedge CLK); #1;
    step(1'b1, 3, 16'h1111, 1'b0, 0, 3, 3);
    RSTn = 1'b1;
    for (int a = 0; a < 16; a++) step(1'b0, 0, 16'h0, 1'b0, 0, a, 15 - a);

    step(1'b1, 3, 16'hA5A5, 1'b0, 0, 3, 0);
    step(1'b0, 0, 16'h0, 1'b0, 0, 3, 3);

    reset_mid();
    step(1'b0, 0, 16'h0, 1'b1, 5, 0, 5);
    repeat (3) step(1'b0, 0, 16'h0, 1'b0, 0, 0, 5);
    step(1'b1, 5, 16'h1234, 1'b0, 0, 0, 5);
    step(1'b0, 0, 16'h0, 1'b0, 0, 5, 5);

    reset_mid();
    step(1'b0, 0, 16'h0, 1'b1, 2, 2, 2);
    step(1'b1, 2, 16'h5A5A, 1'b1, 2, 2, 2);
    step(1'b0, 0, 16'h0, 1'b0, 0, 2, 2);
    step(1'b0, 0, 16'h0, 1'b1, 2, 2, 2);
    repeat (2) step(1'b0, 0, 16'h0, 1'b0, 0, 2, 2);

    reset_mid();
    step(1'b1, 0, 16'hFFFF, 1'b1, 0, 0, 0);
    step(1'b0, 0, 16'h0, 1'b0, 0, 0, 0);
    step(1'b1, 7, 16'h7777, 1'b0, 0, 7, 6);
    step(1'b0, 0, 16'h0, 1'b0, 0, 7, 5);
    step(1'b1, 15, 16'hBEEF, 1'b1, 14, 15, 14);

    reset_mid();
    step(1'b1, 3, 16'hC0DE, 1'b0, 0, 3, 3);
    step(1'b0, 0, 16'h0, 1'b1, 1, 1, 4);
    step(1'b0, 0, 16'h0, 1'b1, 4, 4, 6);
    step(1'b0, 0, 16'h0, 1'b1, 6, 6, 1);
    step(1'b0, 0, 16'h0, 1'b0, 0, 1, 6);
    reset_mid();
    for (int a = 0; a < 8; a++) step(1'b0, 0, 16'h0, 1'b0, 0, a, a + 8);

    for (int n = 0; n < 400; n++) begin
      if (n % 40 == 39) reset_mid();
      else step(1'($urandom), int'($urandom_range(0, 9)), 16'($urandom),
                ($urandom_range(0, 2) == 0), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    end

    @(negedge CLK);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
